// File: rtl/reg_bank_arb_pkg.sv
// Shared definitions for the arbitrated register bank.
// Holds the bank geometry and the FSM state encoding used by reg_bank_arb.
package reg_bank_arb_pkg;

  localparam int unsigned NUM_REQ     = 2;
  localparam int unsigned NUM_ENTRIES = 4;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_bank_arb_reg8_clr.sv
// reg8_clr: one bank entry.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (entry -> 0)
//   clr   - synchronous clear, wins over we
//   we    - write enable, loads d
//   d     - write data
//   q     - stored value
module reg8_clr
  import reg_bank_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bank_arb.sv
// reg_bank_arb: 4 x 8 register bank written by two round-robin arbitrated
// requesters, with a sequential clear sweep.
// Ports:
//   clk          - clock
//   Re           - asynchronous active-low reset
//   req          - level write requests, one bit per requester
//   addr0/addr1  - target entry per requester
//   data0/data1  - write data per requester
//   clr_req      - bank clear request, honoured in IDLE only
//   rd_addr      - read address
//   gnt          - one-hot grant pulse; granted write commits at end of cycle
//   rd_data      - combinational read of the bank
//   busy         - high whenever the FSM is not in IDLE
//   clr_done     - one-cycle pulse when the clear sweep finishes
module reg_bank_arb
  import reg_bank_arb_pkg::*;
(
  input  logic               clk,
  input  logic               Re,
  input  logic [NUM_REQ-1:0] req,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [DATA_W-1:0]  data0,
  input  logic [DATA_W-1:0]  data1,
  input  logic               clr_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [DATA_W-1:0]  rd_data,
  output logic               busy,
  output logic               clr_done
);

  state_t               state, state_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt;
  logic                 clr_done_nxt;
  logic [ADDR_W-1:0]    idx;
  logic                 last;

  logic [ADDR_W-1:0]    addr_w;
  logic [DATA_W-1:0]    data_w;
  logic [NUM_ENTRIES-1:0] wr_en;
  logic [NUM_ENTRIES-1:0] clr_en;
  logic [DATA_W-1:0]    bank_q [NUM_ENTRIES];

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = '0;
    clr_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
        end else if (req != '0) begin
          state_nxt = GRANT;
          // On a tie the requester not served last wins.
          if (req == 2'b11) gnt_nxt = last ? 2'b01 : 2'b10;
          else              gnt_nxt = req;
        end
      end
      GRANT: state_nxt = IDLE;
      CLEAR: begin
        if (idx == ADDR_W'(NUM_ENTRIES - 1)) begin
          state_nxt    = DONE;
          clr_done_nxt = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      state    <= IDLE;
      gnt      <= '0;
      clr_done <= 1'b0;
      idx      <= '0;
      last     <= 1'b1;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      clr_done <= clr_done_nxt;
      if (state == IDLE && clr_req) idx <= '0;
      else if (state == CLEAR)      idx <= idx + 1'b1;
      if (state == GRANT)           last <= gnt[1];
    end
  end

  // The registered grant identifies the winner during GRANT, so no separate
  // winner register is kept; requesters hold addr/data until granted.
  assign addr_w = gnt[1] ? addr1 : addr0;
  assign data_w = gnt[1] ? data1 : data0;

  always_comb begin
    wr_en  = '0;
    clr_en = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      wr_en[i]  = (state == GRANT) && (addr_w == ADDR_W'(i));
      clr_en[i] = (state == CLEAR) && (idx == ADDR_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_bank
    reg8_clr u_reg (
      .clk   (clk),
      .rst_n (Re),
      .clr   (clr_en[g]),
      .we    (wr_en[g]),
      .d     (data_w),
      .q     (bank_q[g])
    );
  end

  assign rd_data = bank_q[rd_addr];
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_reg_bank_arb.sv
module tb_reg_bank_arb;

  logic       clk;
  logic       Re;
  logic [1:0] req;
  logic [1:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       clr_req;
  logic [1:0] rd_addr;
  logic [1:0] gnt;
  logic [7:0] rd_data;
  logic       busy;
  logic       clr_done;

  int total = 0;
  int bad   = 0;

  reg_bank_arb dut (
    .clk      (clk),
    .Re       (Re),
    .req      (req),
    .addr0    (addr0),
    .addr1    (addr1),
    .data0    (data0),
    .data1    (data1),
    .clr_req  (clr_req),
    .rd_addr  (rd_addr),
    .gnt      (gnt),
    .rd_data  (rd_data),
    .busy     (busy),
    .clr_done (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each cycle is described by an activity slot. Activities are scheduled as
  // whole sequences when an idle cycle accepts work; effects on the bank
  // land at the edge that closes the slot.
  typedef struct {
    int       kind;   // 0 idle, 1 write grant, 2 clear entry, 3 clear done
    logic [1:0] g;
    int       idx;
  } slot_t;

  slot_t      cur;
  slot_t      plan[$];
  logic [7:0] mbank [4];
  logic       mlast;

  task automatic model_reset();
    cur.kind = 0; cur.g = 2'b00; cur.idx = 0;
    plan.delete();
    for (int i = 0; i < 4; i++) mbank[i] = 8'h00;
    mlast = 1'b1;
  endtask

  task automatic model_step();
    slot_t old, s;
    old = cur;
    if (old.kind == 1) begin
      if (old.g[1]) mbank[addr1] = data1; else mbank[addr0] = data0;
      mlast = old.g[1];
    end else if (old.kind == 2) begin
      mbank[old.idx] = 8'h00;
    end
    if (old.kind == 0) begin
      if (clr_req) begin
        for (int i = 0; i < 4; i++) begin
          s.kind = 2; s.g = 2'b00; s.idx = i; plan.push_back(s);
        end
        s.kind = 3; s.g = 2'b00; s.idx = 0; plan.push_back(s);
      end else if (req != 2'b00) begin
        s.kind = 1; s.idx = 0;
        if (req == 2'b11) s.g = mlast ? 2'b01 : 2'b10;
        else              s.g = req;
        plan.push_back(s);
      end
    end
    if (plan.size() > 0) cur = plan.pop_front();
    else begin cur.kind = 0; cur.g = 2'b00; cur.idx = 0; end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge Re);
      if (!Re) model_reset();
      else     model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("gnt",      {30'd0, gnt},      {30'd0, cur.g});
      chk("busy",     {31'd0, busy},     {31'd0, (cur.kind != 0)});
      chk("clr_done", {31'd0, clr_done}, {31'd0, (cur.kind == 3)});
      chk("rd_data",  {24'd0, rd_data},  {24'd0, mbank[rd_addr]});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic write0(input logic [1:0] a, input logic [7:0] d);
    req = 2'b01; addr0 = a; data0 = d;
    tick();
    req = 2'b00;
    tick();
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1 chk(name, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic do_reset();
    Re = 1'b0;
    tick(); tick();
    Re = 1'b1;
  endtask

  initial begin
    Re = 1'b0; req = 2'b00; addr0 = 2'd0; addr1 = 2'd0;
    data0 = 8'h00; data1 = 8'h00; clr_req = 1'b0; rd_addr = 2'd0;
    tick(); tick();
    chk("rst_gnt",  {30'd0, gnt},      32'd0);
    chk("rst_busy", {31'd0, busy},     32'd0);
    chk("rst_done", {31'd0, clr_done}, 32'd0);
    for (int i = 0; i < 4; i++) read_chk("rst_bank", 2'(i), 8'h00);
    Re = 1'b1;
    tick();

    // single request: grant one cycle later, data visible the cycle after
    rd_addr = 2'd2;
    req = 2'b01; addr0 = 2'd2; data0 = 8'hA5;
    tick();
    chk("w_gnt", {30'd0, gnt}, 32'd1);
    read_chk("w_old", 2'd2, 8'h00);
    req = 2'b00;
    tick();
    chk("w_gnt_off", {30'd0, gnt}, 32'd0);
    read_chk("w_new", 2'd2, 8'hA5);

    // round robin after reset
    do_reset();
    req = 2'b11; addr0 = 2'd0; data0 = 8'h11; addr1 = 2'd1; data1 = 8'h22;
    tick();
    chk("rr_g0", {30'd0, gnt}, 32'd1);
    req = 2'b10;
    tick();
    chk("rr_idle", {30'd0, gnt}, 32'd0);
    tick();
    chk("rr_g1", {30'd0, gnt}, 32'd2);
    req = 2'b00;
    tick();
    read_chk("rr_b0", 2'd0, 8'h11);
    read_chk("rr_b1", 2'd1, 8'h22);

    // tie with requester 1 served last -> requester 0 wins
    req = 2'b11; addr0 = 2'd3; data0 = 8'h33; addr1 = 2'd2; data1 = 8'h44;
    tick();
    chk("rr_g2", {30'd0, gnt}, 32'd1);
    req = 2'b00;
    tick();

    // clear sweep over a full bank
    for (int i = 0; i < 4; i++) write0(2'(i), 8'hFF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk("clr_busy", {31'd0, busy},     32'd1);
      chk("clr_done", {31'd0, clr_done}, (i == 5) ? 32'd1 : 32'd0);
      tick();
    end
    chk("clr_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) read_chk("clr_bank", 2'(i), 8'h00);

    // clear has priority; pending request served after return to IDLE
    clr_req = 1'b1; req = 2'b10; addr1 = 2'd3; data1 = 8'h5A;
    tick();
    clr_req = 1'b0;
    chk("pri_gnt", {30'd0, gnt}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("pri_done", {31'd0, clr_done}, 32'd1);
    tick();
    chk("pri_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("pri_g1", {30'd0, gnt}, 32'd2);
    req = 2'b00;
    tick();
    read_chk("pri_b3", 2'd3, 8'h5A);

    // reset during the second clear cycle
    for (int i = 0; i < 4; i++) write0(2'(i), 8'hFF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    Re = 1'b0;
    #1;
    chk("ar_gnt",  {30'd0, gnt},      32'd0);
    chk("ar_busy", {31'd0, busy},     32'd0);
    chk("ar_done", {31'd0, clr_done}, 32'd0);
    for (int i = 0; i < 4; i++) read_chk("ar_bank", 2'(i), 8'h00);
    tick();
    Re = 1'b1;
    tick();

    // clear request during GRANT is dropped
    write0(2'd0, 8'h77);
    req = 2'b01; addr0 = 2'd1; data0 = 8'h3C;
    tick();
    clr_req = 1'b1; req = 2'b00;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ig_busy", {31'd0, busy},     32'd0);
      chk("ig_done", {31'd0, clr_done}, 32'd0);
      tick();
    end
    read_chk("ig_b0", 2'd0, 8'h77);
    read_chk("ig_b1", 2'd1, 8'h3C);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_arb.md
REG_BANK_ARB -- requirements
Module: reg_bank_arb

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 Re  input  1  reset, asynchronous, active-low; Re=0 forces reset state immediately.
REQ-003 req  input  2  write request, one bit per requester (0,1); level, held until granted.
REQ-004 addr0, addr1  input  2 each  target entry for requester 0/1; stable while its req is high.
REQ-005 data0, data1  input  8 each  write data for requester 0/1; stable while its req is high.
REQ-006 clr_req  input  1  bank-clear request; sampled in IDLE only.
REQ-007 rd_addr  input  2  read address.
REQ-008 gnt  output  2  one-hot grant; one-cycle pulse; write of the granted requester commits at the end of that cycle.
REQ-009 rd_data  output  8  combinational read of bank[rd_addr].
REQ-010 busy  output  1  high whenever state != IDLE.
REQ-011 clr_done  output  1  one-cycle pulse when the clear sweep ends.

Function
REQ-012 Bank: 4 entries x 8 bits, owned by this block, written only by the FSM.
REQ-013 FSM states IDLE, GRANT, CLEAR, DONE; registered state, registered outputs gnt and clr_done.
REQ-014 IDLE with clr_req=1 -> CLEAR, sweep index set to 0; clr_req has priority over req.
REQ-015 IDLE, clr_req=0, req!=0 -> GRANT; winner latched and driven on gnt during GRANT.
REQ-016 Arbitration: single requester wins; both requesting -> requester not granted last wins (round-robin pointer `last`).
REQ-017 GRANT: bank[addr_w] <= data_w at the closing edge, `last` <= w, next state IDLE unconditionally; max throughput one write per 2 cycles.
REQ-018 Request to grant latency: req seen in IDLE cycle N -> gnt high in cycle N+1 -> data visible on rd_data in cycle N+2.
REQ-019 CLEAR: one entry per cycle, bank[idx] <= 0, idx 0..3; after idx=3 -> DONE; exactly 4 CLEAR cycles, idx wraps to 0.
REQ-020 DONE: clr_done=1 for one cycle, next state IDLE.
REQ-021 req asserted during GRANT/CLEAR/DONE: not granted, stays pending, arbitrated on return to IDLE.
REQ-022 clr_req asserted outside IDLE: ignored (not queued).
REQ-023 A requester dropping req before gnt: no write occurs for it; no partial state.
REQ-024 rd_data reflects a write/clear from the cycle after its commit edge; same-cycle read returns old value.

Reset
REQ-025 Re=0: state=IDLE, gnt=00, busy=0, clr_done=0, all bank entries 0x00, sweep index 0, last=1 (requester 0 wins first tie).
REQ-026 Re asserted mid-GRANT or mid-CLEAR: operation aborted, no commit, full reset state; normal operation from the first rising edge with Re=1.

Structure
REQ-027 Shared package: FSM state encoding, NUM_REQ=2, NUM_ENTRIES=4, DATA_W=8.
REQ-028 One sub-module, reg8_clr: 8-bit register with async active-low reset, synchronous clear, write enable; instantiated 4 times for the bank.

Verification
REQ-029 Reset then req=01, addr0=2, data0=0xA5 -> gnt=01 exactly one cycle later, rd_addr=2 reads 0xA5 the cycle after gnt.
REQ-030 After reset, req=11 held (addr0=0/0x11, addr1=1/0x22) -> gnt sequence 01, 10 in alternate cycles; bank[0]=0x11, bank[1]=0x22.
REQ-031 Bank loaded 0xFF all entries, clr_req pulse in IDLE -> busy high 5 cycles, clr_done pulse on cycle 5, all entries read 0x00.
REQ-032 clr_req and req=10 same IDLE cycle -> CLEAR first, then gnt=10 one cycle after return to IDLE; write survives.
REQ-033 Re=0 during CLEAR cycle 2 with bank=0xFF -> all outputs 0 at once, bank all 0x00, state IDLE.
REQ-034 clr_req pulsed during GRANT -> ignored, no clr_done, bank unchanged apart from the granted write.
